// File: rtl/dzcpu_useq_ctrl.sv
// ---------------------------------------------------------------------------
// dzcpu_useq_ctrl
// Micro-op sequencer for the dzcpu core. Holds the micro-PC that addresses
// the ucode ROM and loads it from the main/CB flow LUTs when an opcode is
// dispatched. It steps through a flow until an end-of-flow step retires the
// instruction, and it slips the interrupt-entry flow in between
// instructions. A flow that runs too long, or that steps past the top of
// the ROM, is treated as runaway: the sequencer latches a sticky fault and
// halts until reset.
//
// Ports
//   iClock      core clock, all state on the rising edge
//   iReset      asynchronous active-low reset
//   iMopValid   opcode byte on iMop is valid
//   iMop        current opcode byte (decoded by the external main LUT)
//   iLutIdx     main LUT flow index for iMop
//   iCbLutIdx   CB LUT flow index for the CB-suffix byte
//   iStepEof    unconditional end-of-flow step
//   iStepEofZ   end-of-flow if Z=1
//   iStepEofNz  end-of-flow if Z=0
//   iStepJcb    jump into the CB flow
//   iFlagZ      architectural Z flag
//   iStall      freeze the sequencer this cycle
//   iIrqReq     level interrupt request
//   iIme        interrupt master enable
//   oUopAddr    ucode ROM address (micro-PC)
//   oUopValid   oUopAddr holds an executable uop
//   oRetire     one-cycle pulse after a flow ends
//   oIrqAck     one-cycle pulse while the IRQ flow is being entered
//   oFault      sticky runaway-flow flag
//   oBusy       sequencer is not waiting for an opcode
// ---------------------------------------------------------------------------
module dzcpu_useq_ctrl #(
   parameter logic [7:0] P_IRQ_FLOW = 8'd250,
   parameter logic [5:0] P_MAX_UOPS = 6'd32
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic       iMopValid,
   input  logic [7:0] iMop,
   input  logic [7:0] iLutIdx,
   input  logic [7:0] iCbLutIdx,
   input  logic       iStepEof,
   input  logic       iStepEofZ,
   input  logic       iStepEofNz,
   input  logic       iStepJcb,
   input  logic       iFlagZ,
   input  logic       iStall,
   input  logic       iIrqReq,
   input  logic       iIme,
   output logic [7:0] oUopAddr,
   output logic       oUopValid,
   output logic       oRetire,
   output logic       oIrqAck,
   output logic       oFault,
   output logic       oBusy
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_EXEC,
      S_IRQ,
      S_HALT
   } state_t;

   state_t     state;
   logic [5:0] uopCount;
   logic       flowEnd;
   logic       irqTake;
   logic       runaway;
   logic       unusedMop;

   // The opcode byte itself is decoded by the external LUT; the sequencer
   // only needs the resulting flow indices.
   assign unusedMop = ^iMop;

   // A conditional end step that fails its Z test simply falls through to
   // the next uop. The uop counter holds the number of the uop now at
   // oUopAddr, so reaching the limit without ending is a runaway. Stepping
   // +1 past 8'hFF would wrap into unrelated flows, so that also counts.
   always_comb begin
      flowEnd = iStepEof | (iStepEofZ & iFlagZ) | (iStepEofNz & ~iFlagZ);
      irqTake = iIrqReq & iIme;
      runaway = (uopCount >= P_MAX_UOPS) | (~iStepJcb & (oUopAddr == 8'hFF));
   end

   // Sequencer FSM with registered outputs. Retire/ack are single-cycle
   // pulses cleared every cycle by default; a stall freezes everything else.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state     <= S_WAIT;
         uopCount  <= 6'd0;
         oUopAddr  <= 8'd0;
         oUopValid <= 1'b0;
         oRetire   <= 1'b0;
         oIrqAck   <= 1'b0;
         oFault    <= 1'b0;
         oBusy     <= 1'b0;
      end else begin
         oRetire <= 1'b0;
         oIrqAck <= 1'b0;
         if (!iStall) begin
            case (state)
               S_WAIT: begin
                  if (irqTake) begin
                     state     <= S_IRQ;
                     oIrqAck   <= 1'b1;
                     oUopValid <= 1'b0;
                     oBusy     <= 1'b1;
                  end else if (iMopValid) begin
                     state     <= S_EXEC;
                     oUopAddr  <= iLutIdx;
                     uopCount  <= 6'd1;
                     oUopValid <= 1'b1;
                     oBusy     <= 1'b1;
                  end
               end
               S_EXEC: begin
                  if (flowEnd) begin
                     oRetire   <= 1'b1;
                     uopCount  <= 6'd0;
                     oUopValid <= 1'b0;
                     if (irqTake) begin
                        state   <= S_IRQ;
                        oIrqAck <= 1'b1;
                        oBusy   <= 1'b1;
                     end else begin
                        state <= S_WAIT;
                        oBusy <= 1'b0;
                     end
                  end else if (runaway) begin
                     state     <= S_HALT;
                     oFault    <= 1'b1;
                     oUopValid <= 1'b0;
                     oBusy     <= 1'b0;
                  end else if (iStepJcb) begin
                     oUopAddr <= iCbLutIdx;
                     uopCount <= uopCount + 6'd1;
                  end else begin
                     oUopAddr <= oUopAddr + 8'd1;
                     uopCount <= uopCount + 6'd1;
                  end
               end
               S_IRQ: begin
                  state     <= S_EXEC;
                  oUopAddr  <= P_IRQ_FLOW;
                  uopCount  <= 6'd1;
                  oUopValid <= 1'b1;
                  oBusy     <= 1'b1;
               end
               S_HALT: begin
                  state <= S_HALT;
               end
            endcase
         end
      end
   end

endmodule
